// File: rtl/instr_encoder.sv
// RV32I instruction encoder feeding the boot loader's instruction-memory write port.
// Define ENC_RANGE_CHECK_EN to reject immediates that do not fit their format.
module instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                MAX_WORDS = 256,
  parameter int                CNT_W     = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_op,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ENC  = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;

  localparam logic [2:0] F_I = 3'd0;
  localparam logic [2:0] F_S = 3'd1;
  localparam logic [2:0] F_B = 3'd2;
  localparam logic [2:0] F_J = 3'd3;
  localparam logic [2:0] F_U = 3'd4;

  localparam logic [6:0] OP_R = 7'b0110011;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } fields_t;

  logic [1:0]        state_q, state_d;
  fields_t           fld_q, fld_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              err_q, err_d;

  logic [31:0] word;
  logic        legal;
  logic        range_ok;

  always_comb begin
    word  = '0;
    legal = 1'b1;
    case (fld_q.fmt)
      F_I: word = (fld_q.op == OP_R)
                ? {fld_q.f7, fld_q.rs2, fld_q.rs1, fld_q.f3, fld_q.rd, fld_q.op}
                : {fld_q.imm[11:0], fld_q.rs1, fld_q.f3, fld_q.rd, fld_q.op};
      F_S: word = {fld_q.imm[11:5], fld_q.rs2, fld_q.rs1, fld_q.f3, fld_q.imm[4:0], fld_q.op};
      F_B: word = {fld_q.imm[12], fld_q.imm[10:5], fld_q.rs2, fld_q.rs1, fld_q.f3,
                   fld_q.imm[4:1], fld_q.imm[11], fld_q.op};
      F_J: word = {fld_q.imm[20], fld_q.imm[10:1], fld_q.imm[11], fld_q.imm[19:12],
                   fld_q.rd, fld_q.op};
      F_U: word = {fld_q.imm[31:12], fld_q.rd, fld_q.op};
      default: legal = 1'b0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // A signed value fits in N bits when every bit above N-1 matches the sign bit.
  always_comb begin
    range_ok = 1'b1;
    case (fld_q.fmt)
      F_I: if (fld_q.op != OP_R) range_ok = (fld_q.imm[31:11] == {21{fld_q.imm[11]}});
      F_S: range_ok = (fld_q.imm[31:11] == {21{fld_q.imm[11]}});
      F_B: range_ok = (fld_q.imm[31:12] == {20{fld_q.imm[12]}}) && !fld_q.imm[0];
      F_J: range_ok = (fld_q.imm[31:20] == {12{fld_q.imm[20]}}) && !fld_q.imm[0];
      F_U: range_ok = (fld_q.imm[11:0] == 12'd0);
      default: range_ok = 1'b1;
    endcase
  end
`else
  assign range_ok = 1'b1;
`endif

  assign full     = (count_q == CNT_W'(MAX_WORDS));
  assign in_ready = (state_q == S_IDLE) && !full;

  always_comb begin
    state_d  = state_q;
    fld_d    = fld_q;
    mem_we_d = mem_we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    count_d  = count_q;
    err_d    = err_q;
    if (clr) begin
      // Abort wins over everything, including an ack landing this cycle.
      state_d  = S_IDLE;
      mem_we_d = 1'b0;
      addr_d   = BASE_ADDR;
      count_d  = '0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid && in_ready) begin
          fld_d   = '{fmt: in_fmt, op: in_op, f3: in_funct3, f7: in_funct7,
                      rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
          state_d = S_ENC;
        end
        S_ENC: if (!legal || !range_ok) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          wdata_d  = word;
          mem_we_d = 1'b1;
          state_d  = S_WR;
        end
        S_WR: if (mem_ack) begin
          mem_we_d = 1'b0;
          addr_d   = addr_q + ADDR_W'(4);
          count_d  = count_q + CNT_W'(1);
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      fld_q    <= '0;
      mem_we_q <= 1'b0;
      addr_q   <= BASE_ADDR;
      wdata_q  <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      fld_q    <= fld_d;
      mem_we_q <= mem_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign count     = count_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed + randomized bench for instr_encoder against a field-arithmetic reference model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_fmt = '0;
  logic [6:0]  in_op = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [8:0]  count;
  logic        full;
  logic        err;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_addr = 0;
  int          exp_count = 0;
  logic        exp_err = 0;

  instr_encoder dut (
    .clk(clk), .reset(reset), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_op(in_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .count(count), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Builds the word by placing each field at its bit offset with shifts and adds.
  function automatic void model(input logic [2:0] fmt, input logic [6:0] op,
                                input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [31:0] imm,
                                output bit ok, output logic [31:0] w);
    bit [31:0] o, d, f, a, b, s, u;
    int si;
    o = 32'(op); d = 32'(rd); f = 32'(f3); a = 32'(rs1); b = 32'(rs2); s = 32'(f7);
    u = imm;
    si = $signed(imm);
    ok = 1'b1;
    w = 0;
    case (fmt)
      3'd0: if (op == 7'h33) w = o + (d << 7) + (f << 12) + (a << 15) + (b << 20) + (s << 25);
            else w = o + (d << 7) + (f << 12) + (a << 15) + ((u & 32'hFFF) << 20);
      3'd1: w = o + ((u & 31) << 7) + (f << 12) + (a << 15) + (b << 20) + (((u >> 5) & 127) << 25);
      3'd2: w = o + (((u >> 11) & 1) << 7) + (((u >> 1) & 15) << 8) + (f << 12) + (a << 15)
              + (b << 20) + (((u >> 5) & 63) << 25) + (((u >> 12) & 1) << 31);
      3'd3: w = o + (d << 7) + (((u >> 12) & 255) << 12) + (((u >> 11) & 1) << 20)
              + (((u >> 1) & 1023) << 21) + (((u >> 20) & 1) << 31);
      3'd4: w = o + (d << 7) + (u & 32'hFFFFF000);
      default: ok = 1'b0;
    endcase
`ifdef ENC_RANGE_CHECK_EN
    case (fmt)
      3'd0: if (op != 7'h33 && (si < -2048 || si > 2047)) ok = 1'b0;
      3'd1: if (si < -2048 || si > 2047) ok = 1'b0;
      3'd2: if (si < -4096 || si > 4094 || (si % 2) != 0) ok = 1'b0;
      3'd3: if (si < -(1 << 20) || si > (1 << 20) - 2 || (si % 2) != 0) ok = 1'b0;
      3'd4: if ((u % 4096) != 0) ok = 1'b0;
      default: ;
    endcase
`else
    if (si == 0) ok = ok;
`endif
  endfunction

  // One full transaction from IDLE; ack after `dly` stalled WR cycles.
  task automatic send(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input int dly);
    bit ok;
    logic [31:0] w;
    model(fmt, op, f3, f7, rd, rs1, rs2, imm, ok, w);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_fmt = fmt; in_op = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_we_enc"}, 32'(mem_we), 32'd0);
    step();
    if (ok) begin
      chk({tag, "_we"}, 32'(mem_we), 32'd1);
      chk({tag, "_addr"}, mem_addr, exp_addr);
      chk({tag, "_wdata"}, mem_wdata, w);
      for (int k = 0; k < dly; k++) begin
        step();
        chk({tag, "_stall_we"}, 32'(mem_we), 32'd1);
        chk({tag, "_stall_addr"}, mem_addr, exp_addr);
        chk({tag, "_stall_wdata"}, mem_wdata, w);
      end
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      exp_addr += 4;
      exp_count++;
      chk({tag, "_we_done"}, 32'(mem_we), 32'd0);
    end else begin
      exp_err = 1'b1;
      chk({tag, "_we_rej"}, 32'(mem_we), 32'd0);
    end
    chk({tag, "_count"}, 32'(count), 32'(exp_count));
    chk({tag, "_addr_after"}, mem_addr, exp_addr);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [6:0]  op;

    step();
    step();
    reset = 1'b0;
    step();
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    send("addi", 3'd0, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 0);
    chk("addi_const", mem_wdata, 32'h00500093);
    send("sw", 3'd1, 7'b0100011, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 0);
    chk("sw_const", mem_wdata, 32'h0020A423);
    send("beq", 3'd2, 7'b1100011, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 1);
    chk("beq_const", mem_wdata, 32'hFE000EE3);
    send("lui", 3'd4, 7'b0110111, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 0);
    chk("lui_const", mem_wdata, 32'h123452B7);
    send("add", 3'd0, 7'b0110011, 3'd0, 7'h20, 5'd3, 5'd4, 5'd6, 32'hDEADBEEF, 0);
    chk("sub_const", mem_wdata, 32'h406201B3);
    send("addi800", 3'd0, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800, 0);
`ifndef ENC_RANGE_CHECK_EN
    chk("addi800_const", mem_wdata, 32'h80000093);
`endif
    send("stall", 3'd3, 7'b1101111, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000800, 5);
    send("illegal", 3'd6, 7'b0010011, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 0);

    for (int i = 0; i < 40; i++) begin
      fmt = 3'($urandom_range(0, 7));
      op = 7'($urandom);
      if (fmt == 3'd0 && $urandom_range(0, 2) == 0) op = 7'b0110011;
      case ($urandom_range(0, 3))
        0: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        1: imm = $urandom & 32'hFFFFF000;
        2: imm = $urandom;
        default: imm = (32'($urandom_range(0, 8191)) - 32'd4096) & ~32'd1;
      endcase
      send("rand", fmt, op, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
           5'($urandom), imm, $urandom_range(0, 3));
    end

    // Abort in WR with a simultaneous ack: write is dropped, counters cleared.
    in_fmt = 3'd0; in_op = 7'b0010011; in_imm = 32'd1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("clr_pre_we", 32'(mem_we), 32'd1);
    clr = 1'b1; mem_ack = 1'b1;
    step();
    clr = 1'b0; mem_ack = 1'b0;
    exp_addr = 0; exp_count = 0; exp_err = 0;
    chk("clr_we", 32'(mem_we), 32'd0);
    chk("clr_addr", mem_addr, 32'd0);
    chk("clr_count", 32'(count), 32'd0);
    chk("clr_err", 32'(err), 32'd0);

    for (int i = 0; i < 256; i++)
      send("fill", 3'd0, 7'b0010011, 3'd0, 7'd0, 5'd2, 5'd2, 5'd0, 32'(i), 0);
    chk("full_flag", 32'(full), 32'd1);
    chk("full_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd256);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("full_no_we", 32'(mem_we), 32'd0);
      chk("full_hold_cnt", 32'(count), 32'd256);
    end
    in_valid = 1'b0;
    chk("full_wrap_addr", mem_addr, 32'd1024);
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_addr = 0; exp_count = 0;
    chk("unfull_flag", 32'(full), 32'd0);
    chk("unfull_ready", 32'(in_ready), 32'd1);
    chk("unfull_addr", mem_addr, 32'd0);

    send("post_clr", 3'd4, 7'b0010111, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'hABCDE000, 0);

    // Async reset in the middle of a WR cycle.
    in_fmt = 3'd0; in_op = 7'b0010011; in_imm = 32'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("arst_pre_we", 32'(mem_we), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_we", 32'(mem_we), 32'd0);
    chk("arst_addr", mem_addr, 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_wdata", mem_wdata, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
